// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the MEM pipeline stage.
package cpu_pkg;
    typedef enum logic {IDLE, REQ} mem_state_t;
    localparam int MEM_RD = 0;
    localparam int MEM_WR = 1;
    localparam int PC_TO_MEM = 2;
    localparam logic [1:0] WB_BUBBLE = 2'b00;
    localparam logic [2:0] M_BUBBLE = 3'b000;
endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: data-memory handshake FSM and pipeline stall generation.
module mem_ctrl import cpu_pkg::*; #(
    parameter int DW = 16,
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  logic          mem_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          stall
);
    mem_state_t state, state_next;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_next;
    // start reflects the entry EX/MEM loads this edge; it only loads when not stalled
    always_comb begin
        state_next = (state == IDLE || mem_ack) ? (start ? REQ : IDLE) : REQ;
    end
    assign mem_req = (state == REQ);
    assign mem_we = mem_req && we;
    assign mem_addr = mem_req ? addr : '0;
    assign mem_wdata = mem_req ? wdata : '0;
    assign stall = mem_req && !mem_ack;
endmodule

// File: rtl/mem_slice.sv
// mem_slice: MEM pipeline stage holding EX/MEM and MEM/WB registers around mem_ctrl.
module mem_slice import cpu_pkg::*; #(
    parameter int DW = 16,
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    WB_in,
    input  logic [2:0]    M_in,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data,
    input  logic [DW-1:0] result,
    input  logic [2:0]    flags,
    input  logic [DW-1:0] PCcall,
    input  logic          flush,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          stall,
    output logic [1:0]    WB_out,
    output logic [DW-1:0] wb_data,
    output logic [2:0]    flags_out
);
    logic [1:0]    ex_wb;
    logic [1:0]    ex_m;
    logic [AW-1:0] ex_addr;
    logic [DW-1:0] ex_wdata;
    logic [DW-1:0] ex_result;
    logic [2:0]    ex_flags;
    logic          start;
    // PCToMem only steers the store data at capture, so only RD/WR are kept
    assign start = !flush && (M_in[MEM_RD] || M_in[MEM_WR]);
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ex_wb <= WB_BUBBLE;
            ex_m <= M_BUBBLE[MEM_WR:MEM_RD];
            ex_addr <= '0;
            ex_wdata <= '0;
            ex_result <= '0;
            ex_flags <= '0;
        end else if (!stall) begin
            ex_wb <= flush ? WB_BUBBLE : WB_in;
            ex_m <= flush ? M_BUBBLE[MEM_WR:MEM_RD] : M_in[MEM_WR:MEM_RD];
            ex_addr <= flush ? '0 : addr;
            ex_wdata <= flush ? '0 : (M_in[PC_TO_MEM] ? PCcall : data);
            ex_result <= flush ? '0 : result;
            ex_flags <= flush ? '0 : flags;
        end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            WB_out <= WB_BUBBLE;
            wb_data <= '0;
            flags_out <= '0;
        end else if (stall) begin
            WB_out <= WB_BUBBLE;
            wb_data <= '0;
            flags_out <= '0;
        end else begin
            WB_out <= ex_wb;
            wb_data <= (mem_req && ex_m[MEM_RD] && !ex_m[MEM_WR]) ? mem_rdata : ex_result;
            flags_out <= ex_flags;
        end
    mem_ctrl #(.DW(DW), .AW(AW)) u_ctrl (
        .clk(clk),
        .rst(rst),
        .start(start),
        .we(ex_m[MEM_WR]),
        .addr(ex_addr),
        .wdata(ex_wdata),
        .mem_ack(mem_ack),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .stall(stall)
    );
endmodule

// File: tb/tb_mem_slice.sv
// tb_mem_slice: scoreboard bench for the MEM stage handshake and writeback ordering.
module tb_mem_slice;
    logic        clk, rst;
    logic [1:0]  WB_in;
    logic [2:0]  M_in;
    logic [15:0] addr, data, result, PCcall, mem_rdata;
    logic [2:0]  flags;
    logic        flush, mem_ack;
    logic        mem_req, mem_we, stall;
    logic [15:0] mem_addr, mem_wdata, wb_data;
    logic [1:0]  WB_out;
    logic [2:0]  flags_out;
    logic [20:0] exp_q[$];
    int tests, fails, req_cnt, stall_cnt;

    mem_slice #(.DW(16), .AW(16)) dut (
        .clk(clk), .rst(rst), .WB_in(WB_in), .M_in(M_in), .addr(addr), .data(data),
        .result(result), .flags(flags), .PCcall(PCcall), .flush(flush),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
        .WB_out(WB_out), .wb_data(wb_data), .flags_out(flags_out)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] wb, input logic [2:0] m, input logic [15:0] a,
                         input logic [15:0] d, input logic [15:0] r, input logic [2:0] f,
                         input logic [15:0] pc, input logic fl);
        WB_in = wb; M_in = m; addr = a; data = d; result = r; flags = f; PCcall = pc; flush = fl;
    endtask

    task automatic idle_in();
        drive(2'b00, 3'b000, 16'h0, 16'h0, 16'h0, 3'b000, 16'h0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req) req_cnt++;
            if (stall) stall_cnt++;
            if (WB_out != 2'b00) begin
                if (exp_q.size() == 0) check("unexpected_wb", {11'b0, WB_out, wb_data, flags_out}, 32'h0);
                else check("wb_scoreboard", {11'b0, WB_out, wb_data, flags_out}, {11'b0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        tests = 0; fails = 0; req_cnt = 0; stall_cnt = 0;
        rst = 1; mem_ack = 0; mem_rdata = 0;
        drive(2'b11, 3'b011, 16'h1111, 16'h2222, 16'h3333, 3'b111, 16'h4444, 1'b0);
        step(); step();
        check("rst_mem_req", mem_req, 0);
        check("rst_stall", stall, 0);
        check("rst_wb", {WB_out, wb_data, flags_out}, 0);
        check("rst_mem_bus", {mem_we, mem_addr, mem_wdata}, 0);
        idle_in();
        rst = 0;
        step();
        req_cnt = 0;
        // ALU op: writeback one edge after capture, no memory traffic
        drive(2'b01, 3'b000, 16'h0, 16'h0, 16'h1234, 3'b010, 16'h0, 1'b0);
        exp_q.push_back({2'b01, 16'h1234, 3'b010});
        step();
        idle_in();
        check("alu_wb_not_yet", WB_out, 0);
        step();
        check("alu_wb_data", wb_data, 16'h1234);
        check("alu_flags", flags_out, 3'b010);
        step();
        check("alu_no_req", req_cnt, 0);
        // load with ack on third request cycle
        req_cnt = 0; stall_cnt = 0;
        drive(2'b11, 3'b001, 16'h0040, 16'h0, 16'h5555, 3'b001, 16'h0, 1'b0);
        exp_q.push_back({2'b11, 16'hBEEF, 3'b001});
        step();
        idle_in();
        check("ld_req", {mem_req, mem_we, stall}, 3'b101);
        check("ld_addr", mem_addr, 16'h0040);
        step();
        check("ld_bubble", WB_out, 0);
        step();
        mem_ack = 1; mem_rdata = 16'hBEEF;
        #1 check("ld_stall_drop", stall, 0);
        step();
        mem_ack = 0; mem_rdata = 0;
        check("ld_wb_data", wb_data, 16'hBEEF);
        check("ld_done", mem_req, 0);
        step();
        check("ld_req_cycles", req_cnt, 3);
        check("ld_stall_cycles", stall_cnt, 2);
        // call push: PCcall replaces store data
        drive(2'b10, 3'b110, 16'h0100, 16'hFFFF, 16'h0AAA, 3'b100, 16'h0107, 1'b0);
        exp_q.push_back({2'b10, 16'h0AAA, 3'b100});
        step();
        idle_in();
        check("call_we", {mem_req, mem_we}, 2'b11);
        check("call_wdata", mem_wdata, 16'h0107);
        check("call_addr", mem_addr, 16'h0100);
        mem_ack = 1; mem_rdata = 16'hDEAD;
        step();
        mem_ack = 0;
        check("call_wb_result", wb_data, 16'h0AAA);
        step();
        // back-to-back loads
        req_cnt = 0;
        drive(2'b01, 3'b001, 16'h0010, 16'h0, 16'h0, 3'b000, 16'h0, 1'b0);
        step();
        drive(2'b01, 3'b001, 16'h0020, 16'h0, 16'h0, 3'b011, 16'h0, 1'b0);
        mem_ack = 1; mem_rdata = 16'hA1A1;
        exp_q.push_back({2'b01, 16'hA1A1, 3'b000});
        step();
        idle_in();
        check("b2b_still_req", mem_req, 1);
        check("b2b_addr2", mem_addr, 16'h0020);
        mem_rdata = 16'hB2B2;
        exp_q.push_back({2'b01, 16'hB2B2, 3'b011});
        step();
        mem_ack = 0;
        check("b2b_done", mem_req, 0);
        step();
        check("b2b_req_cycles", req_cnt, 2);
        // flush while stalled is ignored
        drive(2'b01, 3'b001, 16'h0030, 16'h0, 16'h0, 3'b101, 16'h0, 1'b0);
        exp_q.push_back({2'b01, 16'hC3C3, 3'b101});
        step();
        drive(2'b10, 3'b000, 16'h0, 16'h0, 16'h7777, 3'b000, 16'h0, 1'b1);
        step(); step();
        check("flush_stall_addr", mem_addr, 16'h0030);
        idle_in();
        mem_ack = 1; mem_rdata = 16'hC3C3;
        step();
        mem_ack = 0;
        step();
        // flush with stall low captures a bubble
        req_cnt = 0;
        drive(2'b11, 3'b001, 16'h0050, 16'h0, 16'h9999, 3'b111, 16'h0, 1'b1);
        step();
        idle_in();
        check("flush_no_req", mem_req, 0);
        step();
        check("flush_wb_bubble", WB_out, 0);
        check("flush_req_cycles", req_cnt, 0);
        // reset in REQ abandons the access; stale ack ignored
        drive(2'b01, 3'b001, 16'h0060, 16'h0, 16'h0, 3'b000, 16'h0, 1'b0);
        step();
        idle_in();
        check("rreq_req", mem_req, 1);
        rst = 1;
        #1 check("rreq_async", {mem_req, mem_we, stall, mem_addr}, 0);
        step();
        rst = 0;
        step();
        mem_ack = 1; mem_rdata = 16'h6666;
        #1 check("stale_ack_stall", stall, 0);
        step();
        mem_ack = 0;
        check("stale_ack_req", mem_req, 0);
        step();
        check("stale_ack_wb", {WB_out, wb_data, flags_out}, 0);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
